// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the micro-step sequencer: micro-states, opcodes, opcode classes and the
// per-class step table.
package cpu_seq_pkg;

  localparam logic [7:0] ST_NEXT        = 8'h00;
  localparam logic [7:0] ST_FETCH_PC    = 8'h01;
  localparam logic [7:0] ST_FETCH_INST  = 8'h02;
  localparam logic [7:0] ST_HALT        = 8'h03;
  localparam logic [7:0] ST_MOV_FETCH   = 8'h04;
  localparam logic [7:0] ST_MOV_LOAD    = 8'h05;
  localparam logic [7:0] ST_MOV_STORE   = 8'h06;
  localparam logic [7:0] ST_ALU_OP      = 8'h07;
  localparam logic [7:0] ST_LDI         = 8'h08;
  localparam logic [7:0] ST_JUMP        = 8'h09;
  localparam logic [7:0] ST_SET_ADDR    = 8'h0A;
  localparam logic [7:0] ST_OUT         = 8'h0B;
  localparam logic [7:0] ST_IN          = 8'h0C;
  localparam logic [7:0] ST_TMP_STORE   = 8'h0D;
  localparam logic [7:0] ST_FETCH_SP    = 8'h0E;
  localparam logic [7:0] ST_PC_STORE    = 8'h0F;
  localparam logic [7:0] ST_TMP_JUMP    = 8'h10;
  localparam logic [7:0] ST_INC_SP      = 8'h11;
  localparam logic [7:0] ST_RET         = 8'h12;
  localparam logic [7:0] ST_IRQ_SAVE_SP = 8'h13;
  localparam logic [7:0] ST_IRQ_VECTOR  = 8'h14;

  // 8080-flavoured codes; HLT sits inside the MOV pattern and must win over it.
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HLT  = 8'h76;
  localparam logic [7:0] OP_JMP  = 8'hC3;
  localparam logic [7:0] OP_RET  = 8'hC9;
  localparam logic [7:0] OP_CALL = 8'hCD;
  localparam logic [7:0] OP_OUT  = 8'hD3;
  localparam logic [7:0] OP_IN   = 8'hDB;

  localparam logic [7:0] PAT_MOV = 8'b01??_????;
  localparam logic [7:0] PAT_ALU = 8'b10??_????;
  localparam logic [7:0] PAT_LDI = 8'b00??_?110;

  typedef enum logic [3:0] {
    ClsNop, ClsHlt, ClsMov, ClsAlu, ClsLdi, ClsJmp, ClsOut, ClsIn, ClsCall, ClsRet
  } cls_t;

  function automatic logic [7:0] step_of(input cls_t cls, input int unsigned cyc);
    logic [7:0] st;
    st = ST_NEXT;
    if (cyc == 0) begin
      st = ST_FETCH_PC;
    end else if (cyc == 1) begin
      st = ST_FETCH_INST;
    end else begin
      case (cls)
        ClsHlt: if (cyc == 2) st = ST_HALT;
        ClsMov: begin
          case (cyc)
            2: st = ST_MOV_FETCH;
            3: st = ST_MOV_LOAD;
            4: st = ST_MOV_STORE;
            default: st = ST_NEXT;
          endcase
        end
        ClsAlu: if (cyc == 2) st = ST_ALU_OP;
        ClsLdi: begin
          if (cyc == 2) st = ST_FETCH_PC;
          else if (cyc == 3) st = ST_LDI;
        end
        ClsJmp: begin
          if (cyc == 2) st = ST_FETCH_PC;
          else if (cyc == 3) st = ST_JUMP;
        end
        ClsOut, ClsIn: begin
          case (cyc)
            2: st = ST_FETCH_PC;
            3: st = ST_SET_ADDR;
            4: st = (cls == ClsOut) ? ST_OUT : ST_IN;
            default: st = ST_NEXT;
          endcase
        end
        ClsCall: begin
          case (cyc)
            2: st = ST_FETCH_PC;
            3: st = ST_TMP_STORE;
            4: st = ST_FETCH_SP;
            5: st = ST_PC_STORE;
            6: st = ST_TMP_JUMP;
            default: st = ST_NEXT;
          endcase
        end
        ClsRet: begin
          case (cyc)
            2: st = ST_INC_SP;
            3: st = ST_FETCH_SP;
            4: st = ST_RET;
            default: st = ST_NEXT;
          endcase
        end
        default: st = ST_NEXT;
      endcase
    end
    return st;
  endfunction

endpackage

// File: rtl/cpu_opcode_classify.sv
// Combinational opcode classifier: exact opcodes first, then wildcard patterns; anything else
// is reported illegal and treated as a NOP.
module cpu_opcode_classify
  import cpu_seq_pkg::*;
(
  input  logic [7:0] opcode_i,
  output cls_t       cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o   = ClsNop;
    legal_o = 1'b1;
    case (opcode_i)
      OP_NOP:  cls_o = ClsNop;
      OP_HLT:  cls_o = ClsHlt;
      OP_JMP:  cls_o = ClsJmp;
      OP_RET:  cls_o = ClsRet;
      OP_CALL: cls_o = ClsCall;
      OP_OUT:  cls_o = ClsOut;
      OP_IN:   cls_o = ClsIn;
      default: begin
        casez (opcode_i)
          PAT_MOV: cls_o = ClsMov;
          PAT_ALU: cls_o = ClsAlu;
          PAT_LDI: cls_o = ClsLdi;
          default: begin
            cls_o   = ClsNop;
            legal_o = 1'b0;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Micro-step sequencer: per-instruction cycle counter and registered micro-state.
// Define CPU_SEQ_IRQ_EN to add the irq/irq_ack interrupt-entry sequence.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 8,
  parameter int unsigned STATE_W    = 8,
  parameter int unsigned CYCLE_W    = 4,
  parameter int unsigned MAX_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset_cycle,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
`ifdef CPU_SEQ_IRQ_EN
  input  logic                irq,
  output logic                irq_ack,
`endif
  output logic [STATE_W-1:0]  state,
  output logic [CYCLE_W-1:0]  cycle,
  output logic                instr_done,
  output logic                illegal_op
);

  localparam logic [CYCLE_W-1:0] CycLast = CYCLE_W'(MAX_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CycTwo  = CYCLE_W'(2);

  cls_t               cls;
  logic               legal;
  logic [7:0]         step;
  logic [STATE_W-1:0] state_d, state_q;
  logic [CYCLE_W-1:0] cycle_d, cycle_q;
  logic               illegal_d, illegal_q;

  cpu_opcode_classify u_classify (
    .opcode_i (8'(opcode)),
    .cls_o    (cls),
    .legal_o  (legal)
  );

`ifdef CPU_SEQ_IRQ_EN
  localparam logic [CYCLE_W-1:0] CycIrq = CYCLE_W'(MAX_CYCLES - 3);
  logic irq_busy_d, irq_busy_q;
  logic irq_ack_d, irq_ack_q;
`endif

  always_comb begin
    step = step_of(cls, 32'(cycle_q));
    if (cycle_q == CycLast) step = ST_NEXT;
    state_d = STATE_W'(step);
    if (step == ST_NEXT) begin
      cycle_d = '0;
    end else if (step == ST_HALT) begin
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_q + CYCLE_W'(1);
    end
    illegal_d = (cycle_q == CycTwo) && !legal;
`ifdef CPU_SEQ_IRQ_EN
    irq_busy_d = irq_busy_q;
    irq_ack_d  = 1'b0;
    // Entry parks the counter at MAX_CYCLES-3 so the cap supplies the closing NEXT.
    if (irq_busy_q) begin
      illegal_d = 1'b0;
      if (cycle_q == CycLast) begin
        state_d    = STATE_W'(ST_NEXT);
        cycle_d    = '0;
        irq_busy_d = 1'b0;
      end else begin
        state_d = STATE_W'((cycle_q == CycIrq) ? ST_PC_STORE : ST_IRQ_VECTOR);
        cycle_d = cycle_q + CYCLE_W'(1);
      end
    end else if (irq && (step == ST_NEXT || state_q == STATE_W'(ST_HALT))) begin
      state_d    = STATE_W'(ST_IRQ_SAVE_SP);
      cycle_d    = CycIrq;
      irq_busy_d = 1'b1;
      irq_ack_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q    <= STATE_W'(ST_NEXT);
      cycle_q    <= '0;
      illegal_q  <= 1'b0;
`ifdef CPU_SEQ_IRQ_EN
      irq_busy_q <= 1'b0;
      irq_ack_q  <= 1'b0;
`endif
    end else if (stall) begin
      illegal_q  <= 1'b0;
`ifdef CPU_SEQ_IRQ_EN
      irq_ack_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      illegal_q  <= illegal_d;
`ifdef CPU_SEQ_IRQ_EN
      irq_busy_q <= irq_busy_d;
      irq_ack_q  <= irq_ack_d;
`endif
    end
  end

  assign state      = state_q;
  assign cycle      = cycle_q;
  assign instr_done = (state_q == STATE_W'(ST_NEXT));
  assign illegal_op = illegal_q;
`ifdef CPU_SEQ_IRQ_EN
  assign irq_ack    = irq_ack_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed vector-table bench for cpu_sequencer, plus hand-written HALT/reset and IRQ sequences.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_cycle;
  logic [7:0] opcode;
  logic       stall;
  logic [7:0] state;
  logic [3:0] cycle;
  logic       instr_done;
  logic       illegal_op;
`ifdef CPU_SEQ_IRQ_EN
  logic       irq;
  logic       irq_ack;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] op;
    logic       stall;
    logic [7:0] st;
    logic [3:0] cyc;
    logic       ill;
  } vec_t;

  vec_t vq[$];

  cpu_sequencer dut (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .opcode      (opcode),
    .stall       (stall),
`ifdef CPU_SEQ_IRQ_EN
    .irq         (irq),
    .irq_ack     (irq_ack),
`endif
    .state       (state),
    .cycle       (cycle),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] op, input logic stl, input logic [7:0] st,
                     input logic [3:0] cyc, input logic ill);
    vec_t v;
    v.op    = op;
    v.stall = stl;
    v.st    = st;
    v.cyc   = cyc;
    v.ill   = ill;
    vq.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] st, input logic [3:0] cyc,
                               input logic ill);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " cycle"}, 32'(cycle), 32'(cyc));
    check({tag, " done"}, 32'(instr_done), 32'(st == ST_NEXT));
    check({tag, " illegal"}, 32'(illegal_op), 32'(ill));
  endtask

  initial begin
    // NOP
    add(OP_NOP, 0, ST_FETCH_PC, 1, 0);   add(OP_NOP, 0, ST_FETCH_INST, 2, 0);
    add(OP_NOP, 0, ST_NEXT, 0, 0);
    // CALL: 8 clocks
    add(OP_CALL, 0, ST_FETCH_PC, 1, 0);  add(OP_CALL, 0, ST_FETCH_INST, 2, 0);
    add(OP_CALL, 0, ST_FETCH_PC, 3, 0);  add(OP_CALL, 0, ST_TMP_STORE, 4, 0);
    add(OP_CALL, 0, ST_FETCH_SP, 5, 0);  add(OP_CALL, 0, ST_PC_STORE, 6, 0);
    add(OP_CALL, 0, ST_TMP_JUMP, 7, 0);  add(OP_CALL, 0, ST_NEXT, 0, 0);
    // MOV: 6 clocks
    add(8'h41, 0, ST_FETCH_PC, 1, 0);    add(8'h41, 0, ST_FETCH_INST, 2, 0);
    add(8'h41, 0, ST_MOV_FETCH, 3, 0);   add(8'h41, 0, ST_MOV_LOAD, 4, 0);
    add(8'h41, 0, ST_MOV_STORE, 5, 0);   add(8'h41, 0, ST_NEXT, 0, 0);
    // MOV with 3 stalled clocks in MOV_LOAD
    add(8'h5A, 0, ST_FETCH_PC, 1, 0);    add(8'h5A, 0, ST_FETCH_INST, 2, 0);
    add(8'h5A, 0, ST_MOV_FETCH, 3, 0);   add(8'h5A, 0, ST_MOV_LOAD, 4, 0);
    add(8'h5A, 1, ST_MOV_LOAD, 4, 0);    add(8'h5A, 1, ST_MOV_LOAD, 4, 0);
    add(8'h5A, 1, ST_MOV_LOAD, 4, 0);    add(8'h5A, 0, ST_MOV_STORE, 5, 0);
    add(8'h5A, 0, ST_NEXT, 0, 0);
    // LDI via wildcard pattern
    add(8'h3E, 0, ST_FETCH_PC, 1, 0);    add(8'h3E, 0, ST_FETCH_INST, 2, 0);
    add(8'h3E, 0, ST_FETCH_PC, 3, 0);    add(8'h3E, 0, ST_LDI, 4, 0);
    add(8'h3E, 0, ST_NEXT, 0, 0);
    // RET
    add(OP_RET, 0, ST_FETCH_PC, 1, 0);   add(OP_RET, 0, ST_FETCH_INST, 2, 0);
    add(OP_RET, 0, ST_INC_SP, 3, 0);     add(OP_RET, 0, ST_FETCH_SP, 4, 0);
    add(OP_RET, 0, ST_RET, 5, 0);        add(OP_RET, 0, ST_NEXT, 0, 0);
    // OUT
    add(OP_OUT, 0, ST_FETCH_PC, 1, 0);   add(OP_OUT, 0, ST_FETCH_INST, 2, 0);
    add(OP_OUT, 0, ST_FETCH_PC, 3, 0);   add(OP_OUT, 0, ST_SET_ADDR, 4, 0);
    add(OP_OUT, 0, ST_OUT, 5, 0);        add(OP_OUT, 0, ST_NEXT, 0, 0);
    // ALU
    add(8'h80, 0, ST_FETCH_PC, 1, 0);    add(8'h80, 0, ST_FETCH_INST, 2, 0);
    add(8'h80, 0, ST_ALU_OP, 3, 0);      add(8'h80, 0, ST_NEXT, 0, 0);
    // Unknown opcode: illegal pulse with the NEXT step, then clean
    add(8'hFF, 0, ST_FETCH_PC, 1, 0);    add(8'hFF, 0, ST_FETCH_INST, 2, 0);
    add(8'hFF, 0, ST_NEXT, 0, 1);        add(OP_NOP, 0, ST_FETCH_PC, 1, 0);
    add(OP_NOP, 0, ST_FETCH_INST, 2, 0); add(OP_NOP, 0, ST_NEXT, 0, 0);
    // HLT is an exact code inside the MOV pattern
    add(OP_HLT, 0, ST_FETCH_PC, 1, 0);   add(OP_HLT, 0, ST_FETCH_INST, 2, 0);
    add(OP_HLT, 0, ST_HALT, 2, 0);

    reset_cycle = 1'b1;
    opcode      = OP_NOP;
    stall       = 1'b0;
`ifdef CPU_SEQ_IRQ_EN
    irq         = 1'b0;
`endif
    #12;
    check_outputs("reset", ST_NEXT, 0, 0);
    reset_cycle = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      opcode = vq[i].op;
      stall  = vq[i].stall;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vq[i].st, vq[i].cyc, vq[i].ill);
    end

    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("halt%0d state", k), 32'(state), 32'(ST_HALT));
      check($sformatf("halt%0d cycle", k), 32'(cycle), 32'd2);
    end

    // Asynchronous reset between edges
    #2 reset_cycle = 1'b1;
    #1;
    check_outputs("async_reset", ST_NEXT, 0, 0);
    #1 reset_cycle = 1'b0;
    opcode = OP_NOP;
    @(posedge clk);
    #1;
    check_outputs("post_reset", ST_FETCH_PC, 1, 0);

`ifdef CPU_SEQ_IRQ_EN
    opcode = 8'h80;
    @(posedge clk); #1;
    check_outputs("irq_fi", ST_FETCH_INST, 2, 0);
    @(posedge clk); #1;
    check_outputs("irq_alu", ST_ALU_OP, 3, 0);
    check("irq_alu ack", 32'(irq_ack), 32'd0);
    irq = 1'b1;
    @(posedge clk); #1;
    check_outputs("irq_save", ST_IRQ_SAVE_SP, 5, 0);
    check("irq_save ack", 32'(irq_ack), 32'd1);
    @(posedge clk); #1;
    check_outputs("irq_pc", ST_PC_STORE, 6, 0);
    check("irq_pc ack", 32'(irq_ack), 32'd0);
    @(posedge clk); #1;
    check_outputs("irq_vec", ST_IRQ_VECTOR, 7, 0);
    @(posedge clk); #1;
    check_outputs("irq_next", ST_NEXT, 0, 0);
    check("irq_next ack", 32'(irq_ack), 32'd0);
    irq = 1'b0;
    @(posedge clk); #1;
    check_outputs("irq_resume", ST_FETCH_PC, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
